grf_mp: RTL
===========

Name: grf_mp

Overview:
- Parametrised successor of the single-write general register file.
- Adds a second write port, a configurable number of registers and data width, optional write-to-read bypass, and a per-register pending (scoreboard) bit.
- Sits in the decode stage of the pipeline.
- Read data feeds operand muxes; pending flags feed the hazard/stall unit.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; register count is 2**ADDR_W.
- BYPASS, 1, 1 = a read returns same-cycle write data for a matching address; 0 = the read returns the stored value.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  read data, port 1.
- rd2  out  DATA_W  read data, port 2.
- busy1  out  1  pending flag of register ra1.
- busy2  out  1  pending flag of register ra2.
- weA  in  1  write enable, port A.
- waA  in  ADDR_W  write address, port A.
- wdA  in  DATA_W  write data, port A.
- pcA  in  32  PC of the instruction writing on port A (trace only).
- weB  in  1  write enable, port B.
- waB  in  ADDR_W  write address, port B.
- wdB  in  DATA_W  write data, port B.
- pcB  in  32  PC of the instruction writing on port B (trace only).
- rsv_en  in  1  reserve request; sets the pending bit of rsv_addr.
- rsv_addr  in  ADDR_W  register to reserve.

Behaviour:
- Reset:
  - reset=0 clears every register and every pending bit immediately, without waiting for clk.
  - rd1/rd2 read 0 and busy1/busy2 read 0 while reset=0, including when reset asserts mid-operation.
  - The first write after reset deasserts takes effect on the next rising clk edge.
- Storage:
  - Register array, 2**ADDR_W entries of DATA_W bits.
  - Writes commit on rising clk when reset=1.
- Write ports:
  - Ports A and B are independent.
  - If weA & weB & waA==waB, port B wins and the register takes wdB.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are discarded; register 0 always reads 0.
  - rsv_en to address 0 is ignored; busy for address 0 is always 0.
  - Bypass never applies to address 0.
- Reads (combinational, zero latency):
  - rdN = register[raN], subject to bypass.
  - BYPASS=1: if weB & waB==raN, rdN=wdB; else if weA & waA==raN, rdN=wdA; else the stored value. The bypass is suppressed for address 0 when ZERO_REG=1.
  - BYPASS=0: rdN shows the stored value only; new data is visible the cycle after the write edge.
- Pending scoreboard:
  - One bit per register, updated on rising clk.
  - A write on either port to address X clears pending[X].
  - rsv_en to X sets pending[X].
  - Set and clear of the same X in one cycle: the set wins (a newer producer was issued).
  - Reserving an already-pending register leaves it pending; no count is kept.
  - busyN = pending[raN] (registered state).
  - With BYPASS=1, busyN is forced to 0 in the cycle a matching write is presented, so the consumer does not stall.
- Address width: all address comparisons use the full ADDR_W bits; there is no wrap-around or aliasing.

Optional Feature:
- Macro GRF_MP_TRACE_EN.
- Defined:
  - On each rising clk with reset=1, every enabled write prints $display("%d@%h: $%d <= %h", $time, pcX, waX, wdX).
  - Port A prints before port B.
  - Writes to address 0 are also printed, with the value as presented.
  - Both ports print even when they collide on one address.
- Undefined: no display statements are compiled. Functional behaviour is identical in both cases.

Test Plan:
- Reset check: hold reset=0 for 2 clks, set ra1=5, ra2=31 -> rd1=rd2=0 and busy1=busy2=0. Assert reset=0 asynchronously mid-cycle after writes -> outputs return to 0 before the next edge.
- Basic write/read: weA=1, waA=3, wdA=32'h1234_5678, one edge, then ra1=3 -> rd1=32'h1234_5678. Write waB=0, wdB=32'hFFFF_FFFF -> ra2=0 reads 0.
- Bypass: BYPASS=1, ra1=7 with weA=1, waA=7, wdA=32'hA5A5_A5A5 in the same cycle -> rd1=32'hA5A5_A5A5 before the edge. BYPASS=0 -> the old value before the edge, the new value after.
- Port collision: weA=weB=1, waA=waB=9, wdA=32'h1, wdB=32'h2 -> register 9 = 32'h2 after the edge.
- Scoreboard: rsv_en=1, rsv_addr=4 -> busy (ra1=4) = 1 next cycle. Write waA=4 with rsv_en=1, rsv_addr=4 in the same cycle -> still busy. Write again without reserve -> busy=0. rsv_addr=0 -> busy stays 0.
- Trace (GRF_MP_TRACE_EN defined): write pcA=32'h3000, waA=2, wdA=32'h10 -> exactly one line containing "@00003000: $ 2 <= 00000010".

Source files
------------

// File: rtl/grf_mp.sv
// Decode-stage general register file: two read ports, two write ports (B wins on a
// collision), optional write-to-read bypass and per-register pending scoreboard.
// Optional write trace is enabled by defining GRF_MP_TRACE_EN.
module grf_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              weA,
  input  logic [ADDR_W-1:0] waA,
  input  logic [DATA_W-1:0] wdA,
  input  logic [31:0]       pcA,
  input  logic              weB,
  input  logic [ADDR_W-1:0] waB,
  input  logic [DATA_W-1:0] wdB,
  input  logic [31:0]       pcB,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;

  logic wr_a_ok;
  logic wr_b_ok;
  logic rsv_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  always_comb begin
    wr_a_ok = weA && !is_zero(waA);
    wr_b_ok = weB && !is_zero(waB);
    rsv_ok  = rsv_en && !is_zero(rsv_addr);
  end

  // Reservation is applied after the clears so a newer producer keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (weA) pending_nxt[waA] = 1'b0;
    if (weB) pending_nxt[waB] = 1'b0;
    if (rsv_ok) pending_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs    <= '{default: '0};
      pending <= '0;
    end else begin
      if (wr_a_ok) regs[waA] <= wdA;
      if (wr_b_ok) regs[waB] <= wdB;
      pending <= pending_nxt;
    end
  end

  logic hit_a1, hit_b1, hit_a2, hit_b2;

  always_comb begin
    hit_a1 = (BYPASS != 0) && weA && (waA == ra1) && !is_zero(ra1);
    hit_b1 = (BYPASS != 0) && weB && (waB == ra1) && !is_zero(ra1);
    hit_a2 = (BYPASS != 0) && weA && (waA == ra2) && !is_zero(ra2);
    hit_b2 = (BYPASS != 0) && weB && (waB == ra2) && !is_zero(ra2);
  end

  // Outputs are gated by reset so a presented write cannot bypass through during reset.
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (reset) begin
      if (is_zero(ra1))  rd1 = '0;
      else if (hit_b1)   rd1 = wdB;
      else if (hit_a1)   rd1 = wdA;
      else               rd1 = regs[ra1];
      if (is_zero(ra2))  rd2 = '0;
      else if (hit_b2)   rd2 = wdB;
      else if (hit_a2)   rd2 = wdA;
      else               rd2 = regs[ra2];
      busy1 = pending[ra1] && !is_zero(ra1) && !(hit_a1 || hit_b1);
      busy2 = pending[ra2] && !is_zero(ra2) && !(hit_a2 || hit_b2);
    end
  end

`ifdef GRF_MP_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (weA) $display("%d@%h: $%d <= %h", $time, pcA, waA, wdA);
      if (weB) $display("%d@%h: $%d <= %h", $time, pcB, waB, wdB);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{pcA, pcB};
`endif

endmodule
